mem_access_stage: RTL and testbench

- Memory stage, directly downstream of the execute stage; consumes its registered outputs: aluop, write address/enable, result/effective address, store data, mult product.
- Runs LB/LW/SB/SW against the data-memory bus with a req/ack handshake, extends load data and forwards a write-back packet.
- Non-memory ops pass through with one-cycle latency.
- Memory ops hold the pipeline through stall_req_o until ack or timeout.

---
 rtl/mem_access_stage_pkg.sv | 46 ++++
 rtl/mem_access_stage_if.sv | 22 ++
 rtl/mem_access_stage_lane_unit.sv | 45 ++++
 rtl/mem_access_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   - aluop encodings for the byte/word loads and stores
//   - FSM state encoding (IDLE / REQ)
//   - zero constants and the latched packet structure
//   - small aluop classification helpers
package mem_access_stage_pkg;

  localparam logic [7:0] MINIMIPS32_LB = 8'h90;
  localparam logic [7:0] MINIMIPS32_LW = 8'h92;
  localparam logic [7:0] MINIMIPS32_SB = 8'h98;
  localparam logic [7:0] MINIMIPS32_SW = 8'h9A;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [63:0] ZERO_DWORD = 64'h0000_0000_0000_0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mem_state_e;

  // Packet held while a bus transaction is outstanding.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [4:0]  wa;
    logic        wreg;
    logic        whilo;
    logic        mreg;
    logic [31:0] wd;
    logic [63:0] mul;
  } mem_pkt_t;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == MINIMIPS32_LB) || (op == MINIMIPS32_LW) ||
           (op == MINIMIPS32_SB) || (op == MINIMIPS32_SW);
  endfunction

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == MINIMIPS32_LB) || (op == MINIMIPS32_LW);
  endfunction

  // Only word accesses carry an alignment requirement.
  function automatic logic is_word_op(input logic [7:0] op);
    return (op == MINIMIPS32_LW) || (op == MINIMIPS32_SW);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// Handshake: the master raises dm_req_o with dm_we_o/dm_addr_o/dm_wdata_o and
// holds all of them stable until the slave returns a single-cycle dm_ack_i;
// dm_rdata_i is only meaningful in the ack cycle. dm_we_o == 0 means a read.
interface mem_access_stage_if;
  logic        dm_req_o;
  logic [3:0]  dm_we_o;
  logic [31:0] dm_addr_o;
  logic [31:0] dm_wdata_o;
  logic        dm_ack_i;
  logic [31:0] dm_rdata_i;

  modport master (
    output dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
    input  dm_ack_i, dm_rdata_i
  );

  modport slave (
    input  dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
    output dm_ack_i, dm_rdata_i
  );
endinterface

// File: rtl/mem_access_stage_lane_unit.sv
// mem_lane_unit: combinational byte-lane logic for the memory stage.
// Lanes are little-endian: lane k occupies bits 8k+7:8k, k = addr[1:0].
// Ports:
//   st_aluop/st_off/st_din -> st_we/st_wdata : store byte enables and data
//   ld_aluop/ld_off/ld_rdata -> ld_data      : load lane select and extension
module mem_lane_unit
  import mem_access_stage_pkg::*;
(
  input  logic [7:0]  st_aluop,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_din,
  output logic [3:0]  st_we,
  output logic [31:0] st_wdata,
  input  logic [7:0]  ld_aluop,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;

  always_comb begin
    st_we    = 4'b0000;
    st_wdata = st_din;
    if (st_aluop == MINIMIPS32_SB) begin
      st_we    = 4'b0001 << st_off;
      // Byte replicated on every lane; the enables pick the one memory keeps.
      st_wdata = {4{st_din[7:0]}};
    end else if (st_aluop == MINIMIPS32_SW) begin
      st_we    = 4'b1111;
    end
  end

  always_comb begin
    ld_shift = ld_rdata >> {ld_off, 3'b000};
    ld_byte  = ld_shift[7:0];
    if (ld_aluop == MINIMIPS32_LB) begin
      ld_data = {{24{ld_byte[7]}}, ld_byte};
    end else begin
      ld_data = ld_rdata;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the pipeline.
// Consumes the registered execute-stage packet, runs LB/LW/SB/SW on the
// data-memory bus and emits a one-cycle write-back pulse per accepted packet.
// Non-memory ops retire one cycle after acceptance.
// Ports:
//   cpu_clk_50M, cpu_rst_n      clock, synchronous active-high reset
//   mem_valid_i / mem_ready_o   upstream handshake; accept = valid & ready
//   mem_*_i                     execute-stage packet fields
//   stall_req_o                 holds the pipeline during memory ops
//   dm                          data-memory bus (master side)
//   wb_*_o                      registered write-back packet, wb_valid_o pulse
//   dbg_state_o                 current FSM state
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       cpu_clk_50M,
  input  logic                       cpu_rst_n,
  input  logic                       mem_valid_i,
  output logic                       mem_ready_o,
  input  logic [7:0]                 mem_aluop_i,
  input  logic [4:0]                 mem_wa_i,
  input  logic                       mem_wreg_i,
  input  logic                       mem_whilo_i,
  input  logic                       mem_mreg_i,
  input  logic [31:0]                mem_wd_i,
  input  logic [31:0]                mem_din_i,
  input  logic [63:0]                mem_mul_i,
  output logic                       stall_req_o,
  mem_access_stage_if.master         dm,
  output logic                       wb_valid_o,
  output logic [4:0]                 wb_wa_o,
  output logic                       wb_wreg_o,
  output logic [31:0]                wb_wd_o,
  output logic                       wb_whilo_o,
  output logic [63:0]                wb_hilo_o,
  output logic                       wb_addr_err_o,
  output logic                       wb_bus_err_o,
  output mem_state_e                 dbg_state_o
);

  // Timeout fires in the ACK_TIMEOUT-th REQ cycle without an ack.
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  mem_pkt_t    pkt_q, pkt_d;

  logic        dm_req_q, dm_req_d;
  logic [3:0]  dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;

  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_wa_q, wb_wa_d;
  logic        wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_wd_q, wb_wd_d;
  logic        wb_whilo_q, wb_whilo_d;
  logic [63:0] wb_hilo_q, wb_hilo_d;
  logic        wb_addr_err_q, wb_addr_err_d;
  logic        wb_bus_err_q, wb_bus_err_d;

  logic        accept;
  logic        in_is_mem;
  logic        timeout_hit;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  mem_lane_unit u_lane (
    .st_aluop (mem_aluop_i),
    .st_off   (mem_wd_i[1:0]),
    .st_din   (mem_din_i),
    .st_we    (st_we),
    .st_wdata (st_wdata),
    .ld_aluop (pkt_q.aluop),
    .ld_off   (pkt_q.wd[1:0]),
    .ld_rdata (dm.dm_rdata_i),
    .ld_data  (ld_data)
  );

  assign mem_ready_o = (state_q == ST_IDLE) & ~cpu_rst_n;
  assign accept      = mem_valid_i & mem_ready_o;
  assign in_is_mem   = is_mem_op(mem_aluop_i);
  assign stall_req_o = (state_q != ST_IDLE) | (accept & in_is_mem);
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pkt_d         = pkt_q;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    // Write-back fields are zero in every cycle that is not a retire.
    wb_valid_d    = 1'b0;
    wb_wa_d       = 5'd0;
    wb_wreg_d     = 1'b0;
    wb_wd_d       = ZERO_WORD;
    wb_whilo_d    = 1'b0;
    wb_hilo_d     = ZERO_DWORD;
    wb_addr_err_d = 1'b0;
    wb_bus_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_is_mem) begin
            wb_valid_d = 1'b1;
            wb_wa_d    = mem_wa_i;
            wb_wreg_d  = mem_wreg_i;
            wb_wd_d    = mem_wd_i;
            wb_whilo_d = mem_whilo_i;
            wb_hilo_d  = mem_mul_i;
          end else if (is_word_op(mem_aluop_i) && (mem_wd_i[1:0] != 2'b00)) begin
            // Misaligned word access: retire as an error without touching the bus.
            wb_valid_d    = 1'b1;
            wb_wa_d       = mem_wa_i;
            wb_wd_d       = mem_wd_i;
            wb_addr_err_d = 1'b1;
          end else begin
            pkt_d.aluop = mem_aluop_i;
            pkt_d.wa    = mem_wa_i;
            pkt_d.wreg  = mem_wreg_i;
            pkt_d.whilo = mem_whilo_i;
            pkt_d.mreg  = mem_mreg_i;
            pkt_d.wd    = mem_wd_i;
            pkt_d.mul   = mem_mul_i;
            cnt_d       = 16'd0;
            dm_req_d    = 1'b1;
            dm_we_d     = st_we;
            dm_addr_d   = {mem_wd_i[31:2], 2'b00};
            dm_wdata_d  = st_wdata;
            state_d     = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (dm.dm_ack_i) begin
          // Ack takes priority over a timeout landing in the same cycle.
          wb_valid_d = 1'b1;
          wb_wa_d    = pkt_q.wa;
          wb_wreg_d  = is_load_op(pkt_q.aluop) ? pkt_q.wreg : 1'b0;
          wb_wd_d    = (is_load_op(pkt_q.aluop) && pkt_q.mreg) ? ld_data : pkt_q.wd;
          wb_whilo_d = pkt_q.whilo;
          wb_hilo_d  = pkt_q.mul;
          dm_req_d   = 1'b0;
          dm_we_d    = 4'b0000;
          dm_addr_d  = ZERO_WORD;
          dm_wdata_d = ZERO_WORD;
          cnt_d      = 16'd0;
          state_d    = ST_IDLE;
        end else if (timeout_hit) begin
          wb_valid_d   = 1'b1;
          wb_wa_d      = pkt_q.wa;
          wb_wd_d      = pkt_q.wd;
          wb_bus_err_d = 1'b1;
          dm_req_d     = 1'b0;
          dm_we_d      = 4'b0000;
          dm_addr_d    = ZERO_WORD;
          dm_wdata_d   = ZERO_WORD;
          cnt_d        = 16'd0;
          state_d      = ST_IDLE;
        end else if (ACK_TIMEOUT != 0) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      pkt_q         <= '0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 4'b0000;
      dm_addr_q     <= ZERO_WORD;
      dm_wdata_q    <= ZERO_WORD;
      wb_valid_q    <= 1'b0;
      wb_wa_q       <= 5'd0;
      wb_wreg_q     <= 1'b0;
      wb_wd_q       <= ZERO_WORD;
      wb_whilo_q    <= 1'b0;
      wb_hilo_q     <= ZERO_DWORD;
      wb_addr_err_q <= 1'b0;
      wb_bus_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pkt_q         <= pkt_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_wa_q       <= wb_wa_d;
      wb_wreg_q     <= wb_wreg_d;
      wb_wd_q       <= wb_wd_d;
      wb_whilo_q    <= wb_whilo_d;
      wb_hilo_q     <= wb_hilo_d;
      wb_addr_err_q <= wb_addr_err_d;
      wb_bus_err_q  <= wb_bus_err_d;
    end
  end

  assign dm.dm_req_o     = dm_req_q;
  assign dm.dm_we_o      = dm_we_q;
  assign dm.dm_addr_o    = dm_addr_q;
  assign dm.dm_wdata_o   = dm_wdata_q;

  assign wb_valid_o    = wb_valid_q;
  assign wb_wa_o       = wb_wa_q;
  assign wb_wreg_o     = wb_wreg_q;
  assign wb_wd_o       = wb_wd_q;
  assign wb_whilo_o    = wb_whilo_q;
  assign wb_hilo_o     = wb_hilo_q;
  assign wb_addr_err_o = wb_addr_err_q;
  assign wb_bus_err_o  = wb_bus_err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change 1 time unit after the
// rising edge, registered outputs are checked in the same window.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [7:0]  mem_aluop_i;
  logic [4:0]  mem_wa_i;
  logic        mem_wreg_i;
  logic        mem_whilo_i;
  logic        mem_mreg_i;
  logic [31:0] mem_wd_i;
  logic [31:0] mem_din_i;
  logic [63:0] mem_mul_i;
  logic        stall_req_o;
  logic        wb_valid_o;
  logic [4:0]  wb_wa_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wd_o;
  logic        wb_whilo_o;
  logic [63:0] wb_hilo_o;
  logic        wb_addr_err_o;
  logic        wb_bus_err_o;
  mem_state_e  dbg_state_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [7:0] OP_ADD = 8'h18;

  mem_access_stage_if dm_if ();

  mem_access_stage #(.ACK_TIMEOUT(16)) dut (
    .cpu_clk_50M   (clk),
    .cpu_rst_n     (rst),
    .mem_valid_i   (mem_valid_i),
    .mem_ready_o   (mem_ready_o),
    .mem_aluop_i   (mem_aluop_i),
    .mem_wa_i      (mem_wa_i),
    .mem_wreg_i    (mem_wreg_i),
    .mem_whilo_i   (mem_whilo_i),
    .mem_mreg_i    (mem_mreg_i),
    .mem_wd_i      (mem_wd_i),
    .mem_din_i     (mem_din_i),
    .mem_mul_i     (mem_mul_i),
    .stall_req_o   (stall_req_o),
    .dm            (dm_if.master),
    .wb_valid_o    (wb_valid_o),
    .wb_wa_o       (wb_wa_o),
    .wb_wreg_o     (wb_wreg_o),
    .wb_wd_o       (wb_wd_o),
    .wb_whilo_o    (wb_whilo_o),
    .wb_hilo_o     (wb_hilo_o),
    .wb_addr_err_o (wb_addr_err_o),
    .wb_bus_err_o  (wb_bus_err_o),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] din, input logic [63:0] mul);
    mem_valid_i = 1'b1;
    mem_aluop_i = op;
    mem_wa_i    = wa;
    mem_wreg_i  = 1'b1;
    mem_whilo_i = 1'b0;
    mem_mreg_i  = is_load_op(op);
    mem_wd_i    = wd;
    mem_din_i   = din;
    mem_mul_i   = mul;
  endtask

  initial begin
    rst = 1'b1;
    dm_if.dm_ack_i   = 1'b0;
    dm_if.dm_rdata_i = 32'h0;
    drive(OP_ADD, 5'd1, 32'h1, 32'h0, 64'h0);

    // Reset with valid high
    repeat (3) tick();
    chk("rst_ready", 64'(mem_ready_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_wb_wd", 64'(wb_wd_o), 64'd0);
    chk("rst_wb_hilo", wb_hilo_o, 64'd0);
    chk("rst_dm_req", 64'(dm_if.dm_req_o), 64'd0);
    chk("rst_dm_we", 64'(dm_if.dm_we_o), 64'd0);
    chk("rst_dm_addr", 64'(dm_if.dm_addr_o), 64'd0);
    chk("rst_dm_wdata", 64'(dm_if.dm_wdata_o), 64'd0);
    chk("rst_stall", 64'(stall_req_o), 64'd0);
    mem_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(mem_ready_o), 64'd1);

    // Non-memory ops back-to-back
    drive(OP_ADD, 5'd5, 32'h1234_5678, 32'h0, 64'h0000_000A_0000_000B);
    #1;
    chk("nm_stall", 64'(stall_req_o), 64'd0);
    tick();
    drive(OP_ADD, 5'd6, 32'hCAFE_F00D, 32'h0, 64'h1);
    chk("nm1_valid", 64'(wb_valid_o), 64'd1);
    chk("nm1_wd", 64'(wb_wd_o), 64'h1234_5678);
    chk("nm1_hilo", wb_hilo_o, 64'h0000_000A_0000_000B);
    chk("nm1_wa", 64'(wb_wa_o), 64'd5);
    chk("nm1_wreg", 64'(wb_wreg_o), 64'd1);
    tick();
    mem_valid_i = 1'b0;
    chk("nm2_valid", 64'(wb_valid_o), 64'd1);
    chk("nm2_wd", 64'(wb_wd_o), 64'hCAFE_F00D);
    chk("nm2_wa", 64'(wb_wa_o), 64'd6);
    tick();
    chk("nm_idle_valid", 64'(wb_valid_o), 64'd0);
    chk("nm_idle_wd", 64'(wb_wd_o), 64'd0);

    // SB to lane 3 with a 3-cycle wait
    drive(MINIMIPS32_SB, 5'd3, 32'h0000_0103, 32'h0000_00FF, 64'h0);
    #1;
    chk("sb_stall_acc", 64'(stall_req_o), 64'd1);
    tick();
    mem_valid_i = 1'b0;
    chk("sb_state", 64'(dbg_state_o), 64'(ST_REQ));
    chk("sb_req", 64'(dm_if.dm_req_o), 64'd1);
    chk("sb_we", 64'(dm_if.dm_we_o), 64'h8);
    chk("sb_wdata", 64'(dm_if.dm_wdata_o), 64'hFFFF_FFFF);
    chk("sb_addr", 64'(dm_if.dm_addr_o), 64'h100);
    chk("sb_ready", 64'(mem_ready_o), 64'd0);
    chk("sb_stall", 64'(stall_req_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sb_wait_req", 64'(dm_if.dm_req_o), 64'd1);
      chk("sb_wait_we", 64'(dm_if.dm_we_o), 64'h8);
      chk("sb_wait_valid", 64'(wb_valid_o), 64'd0);
    end
    dm_if.dm_ack_i = 1'b1;
    tick();
    dm_if.dm_ack_i = 1'b0;
    chk("sb_wb_valid", 64'(wb_valid_o), 64'd1);
    chk("sb_wb_wreg", 64'(wb_wreg_o), 64'd0);
    chk("sb_req_drop", 64'(dm_if.dm_req_o), 64'd0);
    chk("sb_state_idle", 64'(dbg_state_o), 64'(ST_IDLE));
    tick();
    chk("sb_single_pulse", 64'(wb_valid_o), 64'd0);

    // LB lane 2, zero-wait ack, sign extension
    drive(MINIMIPS32_LB, 5'd7, 32'h0000_0102, 32'h0, 64'h0);
    tick();
    mem_valid_i = 1'b0;
    chk("lb_we", 64'(dm_if.dm_we_o), 64'd0);
    chk("lb_addr", 64'(dm_if.dm_addr_o), 64'h100);
    dm_if.dm_ack_i   = 1'b1;
    dm_if.dm_rdata_i = 32'h0080_0000;
    tick();
    dm_if.dm_ack_i   = 1'b0;
    dm_if.dm_rdata_i = 32'h5555_5555;
    chk("lb_valid", 64'(wb_valid_o), 64'd1);
    chk("lb_wd", 64'(wb_wd_o), 64'hFFFF_FF80);
    chk("lb_wreg", 64'(wb_wreg_o), 64'd1);
    chk("lb_wa", 64'(wb_wa_o), 64'd7);

    // LW aligned
    drive(MINIMIPS32_LW, 5'd8, 32'h0000_0200, 32'h0, 64'h0);
    tick();
    mem_valid_i = 1'b0;
    chk("lw_addr", 64'(dm_if.dm_addr_o), 64'h200);
    dm_if.dm_ack_i   = 1'b1;
    dm_if.dm_rdata_i = 32'hDEAD_BEEF;
    tick();
    dm_if.dm_ack_i   = 1'b0;
    chk("lw_valid", 64'(wb_valid_o), 64'd1);
    chk("lw_wd", 64'(wb_wd_o), 64'hDEAD_BEEF);
    chk("lw_bus_err", 64'(wb_bus_err_o), 64'd0);

    // LW misaligned
    drive(MINIMIPS32_LW, 5'd9, 32'h0000_0201, 32'h0, 64'h0);
    tick();
    mem_valid_i = 1'b0;
    chk("mis_req", 64'(dm_if.dm_req_o), 64'd0);
    chk("mis_valid", 64'(wb_valid_o), 64'd1);
    chk("mis_addr_err", 64'(wb_addr_err_o), 64'd1);
    chk("mis_wreg", 64'(wb_wreg_o), 64'd0);
    chk("mis_state", 64'(dbg_state_o), 64'(ST_IDLE));

    // LW with no ack: bus error in the 16th REQ cycle
    drive(MINIMIPS32_LW, 5'd10, 32'h0000_0300, 32'h0, 64'h0);
    tick();
    mem_valid_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_req", 64'(dm_if.dm_req_o), 64'd1);
      chk("to_wait_valid", 64'(wb_valid_o), 64'd0);
    end
    tick();
    chk("to_valid", 64'(wb_valid_o), 64'd1);
    chk("to_bus_err", 64'(wb_bus_err_o), 64'd1);
    chk("to_wreg", 64'(wb_wreg_o), 64'd0);
    chk("to_req_drop", 64'(dm_if.dm_req_o), 64'd0);

    // SW with ack in the timeout cycle: normal retire
    drive(MINIMIPS32_SW, 5'd11, 32'h0000_0400, 32'h1122_3344, 64'h0);
    tick();
    mem_valid_i = 1'b0;
    chk("sw_we", 64'(dm_if.dm_we_o), 64'hF);
    chk("sw_wdata", 64'(dm_if.dm_wdata_o), 64'h1122_3344);
    repeat (15) tick();
    chk("sw_last_req", 64'(dm_if.dm_req_o), 64'd1);
    dm_if.dm_ack_i = 1'b1;
    tick();
    dm_if.dm_ack_i = 1'b0;
    chk("sw_valid", 64'(wb_valid_o), 64'd1);
    chk("sw_bus_err", 64'(wb_bus_err_o), 64'd0);
    chk("sw_wreg", 64'(wb_wreg_o), 64'd0);
    chk("sw_addr_err", 64'(wb_addr_err_o), 64'd0);

    // Reset during REQ, then a late ack
    drive(MINIMIPS32_LW, 5'd12, 32'h0000_0500, 32'h0, 64'h0);
    tick();
    mem_valid_i = 1'b0;
    chk("rq_req", 64'(dm_if.dm_req_o), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("rq_req_drop", 64'(dm_if.dm_req_o), 64'd0);
    chk("rq_valid", 64'(wb_valid_o), 64'd0);
    chk("rq_state", 64'(dbg_state_o), 64'(ST_IDLE));
    chk("rq_ready", 64'(mem_ready_o), 64'd0);
    rst = 1'b0;
    dm_if.dm_ack_i   = 1'b1;
    dm_if.dm_rdata_i = 32'h1234_0000;
    tick();
    dm_if.dm_ack_i = 1'b0;
    chk("late_ack_valid", 64'(wb_valid_o), 64'd0);
    chk("late_ack_state", 64'(dbg_state_o), 64'(ST_IDLE));
    chk("late_ack_req", 64'(dm_if.dm_req_o), 64'd0);
    tick();
    chk("late_ack_valid2", 64'(wb_valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
